// File: rtl/traffic_junction_ctrl.sv
// traffic_junction_ctrl
// Timed phase sequencer for a main/side road junction. Main road rests on
// green; a latched side-road request is served after a minimum main-green
// time, with yellow and all-red clearance phases on both sides.
//
// Optional pedestrian walk support is enabled with the macro
// TRAFFIC_PED_WALK_EN (adds ped_req input and walk output).
//
// State codes are visible on 'phase': MG=0, MY=1, AR1=2, SG=3, SY=4, AR2=5.
// Codes 6/7 are illegal and recover to AR2 on the next edge.
//
// Handshake note: side_req (and ped_req) are plain level/pulse inputs with
// no ready; any cycle they are high is captured into a sticky latch that is
// released only when the side green phase is granted.
module traffic_junction_ctrl #(
    parameter int GREEN_MAIN_MIN = 8,
    parameter int GREEN_SIDE     = 5,
    parameter int YELLOW_T       = 2,
    parameter int ALLRED_T       = 1,
    parameter int TW             = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_req,
`ifdef TRAFFIC_PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [0:2] main_light,
    output logic [0:2] side_light,
    output logic [2:0] phase,
    output logic       req_pend
);

    typedef enum logic [2:0] {
        ST_MG  = 3'd0,
        ST_MY  = 3'd1,
        ST_AR1 = 3'd2,
        ST_SG  = 3'd3,
        ST_SY  = 3'd4,
        ST_AR2 = 3'd5
    } state_t;

    // Lamp encodings in RGY order
    localparam logic [0:2] LAMP_RED    = 3'b100;
    localparam logic [0:2] LAMP_GREEN  = 3'b010;
    localparam logic [0:2] LAMP_YELLOW = 3'b001;

    // Last timer value of each timed phase (duration - 1)
    localparam logic [TW-1:0] L_MG_MIN = TW'(GREEN_MAIN_MIN - 1);
    localparam logic [TW-1:0] L_SG     = TW'(GREEN_SIDE - 1);
    localparam logic [TW-1:0] L_Y      = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] L_AR     = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] L_ONE    = TW'(1);

    // The state is held as a raw 3-bit code so illegal values 6/7 are
    // representable and handled explicitly by the default branch.
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic          r_req;

    logic [2:0]    w_next;
    logic [TW-1:0] w_timer_next;
    logic          w_enter_sg;
    logic          w_req_any;

`ifdef TRAFFIC_PED_WALK_EN
    logic          r_ped;
    logic          r_walk;

    assign w_req_any = r_req | side_req | r_ped | ped_req;
`else
    assign w_req_any = r_req | side_req;
`endif

    // Next-state selection: timed exits, request-gated main green exit
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_MG:   if ((r_timer >= L_MG_MIN) && w_req_any) w_next = ST_MY;
            ST_MY:   if (r_timer == L_Y)  w_next = ST_AR1;
            ST_AR1:  if (r_timer == L_AR) w_next = ST_SG;
            ST_SG:   if (r_timer == L_SG) w_next = ST_SY;
            ST_SY:   if (r_timer == L_Y)  w_next = ST_AR2;
            ST_AR2:  if (r_timer == L_AR) w_next = ST_MG;
            default: w_next = ST_AR2;
        endcase
    end

    // Phase timer: cleared on every state entry, saturating while main green waits
    always_comb begin
        w_timer_next = r_timer + L_ONE;
        if (w_next != r_state) begin
            w_timer_next = '0;
        end else if (r_state == ST_MG) begin
            w_timer_next = (r_timer < L_MG_MIN) ? (r_timer + L_ONE) : r_timer;
        end
    end

    // Service grant happens exactly on the AR1 -> SG edge
    always_comb begin
        w_enter_sg = (r_state == ST_AR1) && (w_next == ST_SG);
    end

    // State register and timer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_AR2;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_next;
        end
    end

    // Side request latch: grant clears, and clear wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req <= 1'b0;
        end else if (w_enter_sg) begin
            r_req <= 1'b0;
        end else if (side_req) begin
            r_req <= 1'b1;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian request latch with the same set/clear rules as the side latch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ped <= 1'b0;
        end else if (w_enter_sg) begin
            r_ped <= 1'b0;
        end else if (ped_req) begin
            r_ped <= 1'b1;
        end
    end

    // Walk is decided at SG entry and held for the whole side green phase
    always_ff @(posedge clk) begin
        if (rst) begin
            r_walk <= 1'b0;
        end else if (w_enter_sg) begin
            r_walk <= r_ped | ped_req;
        end else if (w_next != ST_SG) begin
            r_walk <= 1'b0;
        end
    end

    assign walk = r_walk;
`endif

    // Lamp decode straight from the state register; only one road is ever non-red
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        case (r_state)
            ST_MG:   main_light = LAMP_GREEN;
            ST_MY:   main_light = LAMP_YELLOW;
            ST_SG:   side_light = LAMP_GREEN;
            ST_SY:   side_light = LAMP_YELLOW;
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign phase    = r_state;
    assign req_pend = r_req;

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed testbench for traffic_junction_ctrl (default parameters).
// With TRAFFIC_PED_WALK_EN defined, the pedestrian walk scenario is added.
module tb_traffic_junction_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       side_req;
    logic [0:2] main_light;
    logic [0:2] side_light;
    logic [2:0] phase;
    logic       req_pend;
`ifdef TRAFFIC_PED_WALK_EN
    logic       ped_req;
    logic       walk;
`endif

    int vectors     = 0;
    int miscompares = 0;

    traffic_junction_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .side_req   (side_req),
`ifdef TRAFFIC_PED_WALK_EN
        .ped_req    (ped_req),
        .walk       (walk),
`endif
        .main_light (main_light),
        .side_light (side_light),
        .phase      (phase),
        .req_pend   (req_pend)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion before 100000");
        $fatal(1, "watchdog expired");
    end

    // Expected phase for cycle i counted from the first MG cycle of a served
    // request: MG 8, MY 2, AR1 1, SG 5, SY 2, AR2 1 (period 19).
    function automatic logic [2:0] cyc_phase(input int i);
        int k;
        k = i % 19;
        if (k < 8)       return 3'd0;
        else if (k < 10) return 3'd1;
        else if (k < 11) return 3'd2;
        else if (k < 16) return 3'd3;
        else if (k < 18) return 3'd4;
        else             return 3'd5;
    endfunction

    function automatic logic [0:2] exp_main(input logic [2:0] ph);
        logic [0:2] v;
        case (ph)
            3'd0:    v = 3'b010;
            3'd1:    v = 3'b001;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    function automatic logic [0:2] exp_side(input logic [2:0] ph);
        logic [0:2] v;
        case (ph)
            3'd3:    v = 3'b010;
            3'd4:    v = 3'b001;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    // Driver tasks: outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        side_req = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        ped_req  = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        side_req = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        ped_req  = 1'b0;
`endif
        tick();
        tick();
        vectors++;
        if (phase !== 3'd5 || main_light !== 3'b100 || side_light !== 3'b100 || req_pend !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: phase=%0d main=%b side=%b req=%b, expected phase=5 main=100 side=100 req=0",
                     phase, main_light, side_light, req_pend);
        end
`ifdef TRAFFIC_PED_WALK_EN
        vectors++;
        if (walk !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_walk: walk=%b, expected 0", walk);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 60; i++) begin
            tick();
            vectors++;
            if (phase !== 3'd0 || main_light !== 3'b010 || side_light !== 3'b100 || req_pend !== 1'b0) begin
                miscompares++;
                $display("FAIL idle[%0d]: phase=%0d main=%b side=%b req=%b, expected phase=0 main=010 side=100 req=0",
                         i, phase, main_light, side_light, req_pend);
            end
        end
    endtask

    // MG timer already saturated: a pulse exits MG on the very next edge
    task automatic test_late_req();
        logic [2:0] ep;
        logic       er;
        side_req = 1'b1;
        tick();
        side_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            ep = cyc_phase(8 + i);
            er = (i < 3);
            vectors++;
            if (phase !== ep || main_light !== exp_main(ep) || side_light !== exp_side(ep) || req_pend !== er) begin
                miscompares++;
                $display("FAIL late_req[%0d]: phase=%0d main=%b side=%b req=%b, expected phase=%0d main=%b side=%b req=%b",
                         i, phase, main_light, side_light, req_pend, ep, exp_main(ep), exp_side(ep), er);
            end
            tick();
        end
    endtask

    task automatic test_single_req();
        logic [2:0] ep;
        logic       er;
        do_reset();
        for (int i = 0; i < 27; i++) begin
            ep = cyc_phase(i);
            er = (i >= 2 && i <= 10);
            vectors++;
            if (phase !== ep || main_light !== exp_main(ep) || side_light !== exp_side(ep) || req_pend !== er) begin
                miscompares++;
                $display("FAIL single_req[%0d]: phase=%0d main=%b side=%b req=%b, expected phase=%0d main=%b side=%b req=%b",
                         i, phase, main_light, side_light, req_pend, ep, exp_main(ep), exp_side(ep), er);
            end
            side_req = (i == 1);
            tick();
        end
        side_req = 1'b0;
    endtask

    task automatic test_held_req();
        logic [2:0] ep;
        do_reset();
        side_req = 1'b1;
        for (int i = 0; i < 57; i++) begin
            ep = cyc_phase(i);
            vectors++;
            if (phase !== ep || main_light !== exp_main(ep) || side_light !== exp_side(ep)) begin
                miscompares++;
                $display("FAIL held_req[%0d]: phase=%0d main=%b side=%b, expected phase=%0d main=%b side=%b",
                         i, phase, main_light, side_light, ep, exp_main(ep), exp_side(ep));
            end
            tick();
        end
        side_req = 1'b0;
    endtask

    task automatic test_sg_pulse();
        logic [2:0] ep;
        logic       er;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            ep = cyc_phase(i);
            er = (i >= 2 && i <= 10) || (i >= 14);
            vectors++;
            if (phase !== ep || main_light !== exp_main(ep) || side_light !== exp_side(ep) || req_pend !== er) begin
                miscompares++;
                $display("FAIL sg_pulse[%0d]: phase=%0d main=%b side=%b req=%b, expected phase=%0d main=%b side=%b req=%b",
                         i, phase, main_light, side_light, req_pend, ep, exp_main(ep), exp_side(ep), er);
            end
            side_req = (i == 1 || i == 13);
            tick();
        end
        side_req = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            side_req = (i == 1 || i == 11);
            tick();
        end
        side_req = 1'b0;
        vectors++;
        if (phase !== 3'd3 || req_pend !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset_pre: phase=%0d req=%b, expected phase=3 req=1", phase, req_pend);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (phase !== 3'd5 || main_light !== 3'b100 || side_light !== 3'b100 || req_pend !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: phase=%0d main=%b side=%b req=%b, expected phase=5 main=100 side=100 req=0",
                     phase, main_light, side_light, req_pend);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (phase !== 3'd0 || main_light !== 3'b010 || side_light !== 3'b100) begin
                miscompares++;
                $display("FAIL mid_reset_mg[%0d]: phase=%0d main=%b side=%b, expected phase=0 main=010 side=100",
                         i, phase, main_light, side_light);
            end
        end
    endtask

    task automatic test_illegal();
        force dut.r_state = 3'd7;
        #1;
        release dut.r_state;
        vectors++;
        if (phase !== 3'd7 || main_light !== 3'b100 || side_light !== 3'b100) begin
            miscompares++;
            $display("FAIL illegal_decode: phase=%0d main=%b side=%b, expected phase=7 main=100 side=100",
                     phase, main_light, side_light);
        end
        tick();
        vectors++;
        if (phase !== 3'd5 || main_light !== 3'b100 || side_light !== 3'b100) begin
            miscompares++;
            $display("FAIL illegal_recover: phase=%0d main=%b side=%b, expected phase=5 main=100 side=100",
                     phase, main_light, side_light);
        end
        tick();
        vectors++;
        if (phase !== 3'd0 || main_light !== 3'b010) begin
            miscompares++;
            $display("FAIL illegal_to_mg: phase=%0d main=%b, expected phase=0 main=010", phase, main_light);
        end
    endtask

`ifdef TRAFFIC_PED_WALK_EN
    task automatic test_ped_walk();
        logic [2:0] ep;
        logic       ew;
        do_reset();
        for (int i = 0; i < 27; i++) begin
            ep = cyc_phase(i);
            ew = (i >= 11 && i <= 15);
            vectors++;
            if (phase !== ep || walk !== ew || req_pend !== 1'b0) begin
                miscompares++;
                $display("FAIL ped_walk[%0d]: phase=%0d walk=%b req=%b, expected phase=%0d walk=%b req=0",
                         i, phase, walk, req_pend, ep, ew);
            end
            ped_req = (i == 1);
            tick();
        end
        ped_req = 1'b0;
    endtask
`endif

    // Test sequence and final report
    initial begin
        rst      = 1'b1;
        side_req = 1'b0;
`ifdef TRAFFIC_PED_WALK_EN
        ped_req  = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_idle();
        test_late_req();
        test_single_req();
        test_held_req();
        test_sg_pulse();
        test_mid_reset();
        test_illegal();
`ifdef TRAFFIC_PED_WALK_EN
        test_ped_walk();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
